// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter with downstream PC/valid tracking.
// Generates the IMEM fetch address under a valid/ready handshake, shifts each
// fetched PC through STAGES tracked pipeline slots, and honours redirect
// (highest priority, flushes every slot), stall (freeze) and bubble insertion.

// One tracked pipeline slot: PC plus valid bit.
module pc_fetch_stage #(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                hold,
  input  logic [PC_WIDTH-1:0] load_pc,
  input  logic                load_valid,
  output logic [PC_WIDTH-1:0] pc,
  output logic                valid
);

  // Flush kills the slot but leaves its PC alone (PC is don't-care when invalid).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (!hold) begin
      pc    <= load_pc;
      valid <= load_valid;
    end
  end

endmodule

module pc_fetch_unit #(
  parameter int                     PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC_VAL = '0,
  parameter int                     PC_STEP      = 4,
  parameter int                     STAGES       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect_valid,
  input  logic [PC_WIDTH-1:0]          redirect_pc,
  input  logic                         stall,
  input  logic                         fetch_ready,
  output logic                         fetch_valid,
  output logic [PC_WIDTH-1:0]          fetch_pc,
  output logic [STAGES*PC_WIDTH-1:0]   stage_pc,
  output logic [STAGES-1:0]            stage_valid,
  output logic                         misalign_err
);

  // Low-order bits that must be zero in an aligned PC; empty mask when PC_STEP=1,
  // which avoids a zero-width slice for that case.
  localparam logic [PC_WIDTH-1:0] STEP_MASK = PC_WIDTH'(PC_STEP - 1);
  localparam logic [PC_WIDTH-1:0] STEP_INC  = PC_WIDTH'(PC_STEP);

  logic                               fire;
  logic [PC_WIDTH-1:0]                redirect_aligned;
  logic                               redirect_misaligned;
  logic [STAGES-1:0][PC_WIDTH-1:0]    spc;
  logic [STAGES-1:0][PC_WIDTH-1:0]    spc_in;
  logic [STAGES-1:0]                  svld_in;

  assign fire                = fetch_valid & fetch_ready & ~stall;
  assign redirect_aligned    = redirect_pc & ~STEP_MASK;
  assign redirect_misaligned = |(redirect_pc & STEP_MASK);

  // Fetch PC, request valid and misalign pulse. Redirect wins over stall and fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc     <= RESET_PC_VAL;
      fetch_valid  <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      fetch_valid  <= 1'b1;
      misalign_err <= redirect_valid & redirect_misaligned;
      if (redirect_valid)
        fetch_pc <= redirect_aligned;
      else if (fire)
        fetch_pc <= fetch_pc + STEP_INC;
    end
  end

  // Slot inputs: slot 0 takes the fetched PC on fire, else a bubble that keeps
  // its old PC; deeper slots take their predecessor unconditionally.
  always_comb begin
    spc_in  = '0;
    svld_in = '0;
    spc_in[0]  = fire ? fetch_pc : spc[0];
    svld_in[0] = fire;
    for (int i = 1; i < STAGES; i++) begin
      spc_in[i]  = spc[i-1];
      svld_in[i] = stage_valid[i-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    pc_fetch_stage #(.PC_WIDTH(PC_WIDTH)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect_valid),
      .hold       (stall),
      .load_pc    (spc_in[g]),
      .load_valid (svld_in[g]),
      .pc         (spc[g]),
      .valid      (stage_valid[g])
    );
  end

  assign stage_pc = spc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed table-driven bench for pc_fetch_unit (default parameters:
// 32-bit PC, reset PC 0, step 4, two tracked stages).
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [63:0] stage_pc;
  logic [1:0]  stage_valid;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;

  pc_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .fetch_ready    (fetch_ready),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .stage_pc       (stage_pc),
    .stage_valid    (stage_valid),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        st;
    logic        rdy;
    logic [31:0] epc;
    logic        efv;
    logic [1:0]  esv;
    logic [31:0] es0;
    logic [31:0] es1;
    logic        emis;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic rv, logic [31:0] rpc, logic st, logic rdy,
                              logic [31:0] epc, logic [1:0] esv,
                              logic [31:0] es0, logic [31:0] es1, logic emis);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.st = st; v.rdy = rdy;
    v.epc = epc; v.efv = 1'b1; v.esv = esv; v.es0 = es0; v.es1 = es1; v.emis = emis;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h exp=%h", name, idx, got, exp);
    end
  endtask

  task automatic check_reset_state(input int idx);
    chk("rst_fetch_pc", idx, fetch_pc, 32'h0);
    chk("rst_fetch_valid", idx, {31'b0, fetch_valid}, 32'h0);
    chk("rst_stage_valid", idx, {30'b0, stage_valid}, 32'h0);
    chk("rst_stage0_pc", idx, stage_pc[31:0], 32'h0);
    chk("rst_stage1_pc", idx, stage_pc[63:32], 32'h0);
    chk("rst_misalign", idx, {31'b0, misalign_err}, 32'h0);
  endtask

  initial begin
    // redirect, rpc, stall, ready | fetch_pc, stage_valid, s0pc, s1pc, misalign
    vecs[0]  = mk(0, 0, 0, 1, 32'h0,        2'b00, 0,            0,            0);
    vecs[1]  = mk(0, 0, 0, 1, 32'h4,        2'b01, 32'h0,        0,            0);
    vecs[2]  = mk(0, 0, 0, 1, 32'h8,        2'b11, 32'h4,        32'h0,        0);
    vecs[3]  = mk(0, 0, 0, 0, 32'h8,        2'b10, 0,            32'h4,        0);
    vecs[4]  = mk(0, 0, 0, 0, 32'h8,        2'b00, 0,            0,            0);
    vecs[5]  = mk(0, 0, 0, 1, 32'hC,        2'b01, 32'h8,        0,            0);
    vecs[6]  = mk(0, 0, 0, 1, 32'h10,       2'b11, 32'hC,        32'h8,        0);
    vecs[7]  = mk(0, 0, 1, 1, 32'h10,       2'b11, 32'hC,        32'h8,        0);
    vecs[8]  = mk(0, 0, 1, 1, 32'h10,       2'b11, 32'hC,        32'h8,        0);
    vecs[9]  = mk(0, 0, 1, 1, 32'h10,       2'b11, 32'hC,        32'h8,        0);
    vecs[10] = mk(0, 0, 0, 1, 32'h14,       2'b11, 32'h10,       32'hC,        0);
    vecs[11] = mk(1, 32'h100, 1, 1, 32'h100, 2'b00, 0,           0,            0);
    vecs[12] = mk(0, 0, 0, 1, 32'h104,      2'b01, 32'h100,      0,            0);
    vecs[13] = mk(0, 0, 0, 1, 32'h108,      2'b11, 32'h104,      32'h100,      0);
    vecs[14] = mk(1, 32'h102, 0, 1, 32'h100, 2'b00, 0,           0,            1);
    vecs[15] = mk(0, 0, 0, 0, 32'h100,      2'b00, 0,            0,            0);
    vecs[16] = mk(0, 0, 0, 1, 32'h104,      2'b01, 32'h100,      0,            0);
    vecs[17] = mk(1, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, 2'b00, 0, 0,          0);
    vecs[18] = mk(0, 0, 0, 1, 32'h0,        2'b01, 32'hFFFF_FFFC, 0,           0);
    vecs[19] = mk(0, 0, 0, 1, 32'h4,        2'b11, 32'h0,        32'hFFFF_FFFC, 0);
    vecs[20] = mk(1, 32'h203, 1, 1, 32'h200, 2'b00, 0,           0,            1);
    vecs[21] = mk(0, 0, 1, 1, 32'h200,      2'b00, 0,            0,            0);

    rst = 1'b1; redirect_valid = 0; redirect_pc = 0; stall = 0; fetch_ready = 1;
    #1 check_reset_state(-1);
    // Held in reset across an edge: nothing may come out of reset early.
    @(posedge clk); #1 check_reset_state(-2);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      stall          = vecs[i].st;
      fetch_ready    = vecs[i].rdy;
      @(posedge clk); #1;
      chk("fetch_pc", i, fetch_pc, vecs[i].epc);
      chk("fetch_valid", i, {31'b0, fetch_valid}, {31'b0, vecs[i].efv});
      chk("stage_valid", i, {30'b0, stage_valid}, {30'b0, vecs[i].esv});
      chk("misalign_err", i, {31'b0, misalign_err}, {31'b0, vecs[i].emis});
      if (vecs[i].esv[0]) chk("stage0_pc", i, stage_pc[31:0], vecs[i].es0);
      if (vecs[i].esv[1]) chk("stage1_pc", i, stage_pc[63:32], vecs[i].es1);
      @(negedge clk);
    end

    // Run a few fires, then assert reset mid-cycle: outputs clear with no edge.
    redirect_valid = 0; stall = 0; fetch_ready = 1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_state(100);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_fetch_valid", 101, {31'b0, fetch_valid}, 32'h1);
    chk("post_rst_fetch_pc", 101, fetch_pc, 32'h0);
    @(posedge clk); #1;
    chk("post_rst_fetch_pc", 102, fetch_pc, 32'h4);
    chk("post_rst_stage_valid", 102, {30'b0, stage_valid}, 32'h1);
    chk("post_rst_stage0_pc", 102, stage_pc[31:0], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
